// File: rtl/ssm_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared encapsulation datapath.
// Streams one whole packet per grant, then holds an inter-packet gap.
module ssm_pkt_arbiter #(
  parameter int N_SRC      = 4,
  parameter int IPG_CYCLES = 8,
  parameter int MAX_WORDS  = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     iv_src_en,
  input  logic [N_SRC-1:0]     iv_pkt_valid,
  input  logic [134*N_SRC-1:0] iv_data,
  output logic [N_SRC-1:0]     ov_rd,
  output logic [N_SRC-1:0]     ov_pkt_done,
  output logic [133:0]         ov_data,
  output logic                 o_data_wr,
  output logic [2:0]           ov_grant_id,
  output logic                 o_busy,
  output logic [31:0]          ov_pkt_cnt,
  output logic [15:0]          ov_err_cnt
);

  localparam int IW  = $clog2(N_SRC);
  localparam int WCW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_GAP} state_t;

  state_t           state, state_nx;
  logic [2:0]       rr_ptr, grant;
  logic [WCW-1:0]   word_cnt;
  logic [7:0]       gap_cnt;
  logic [N_SRC-1:0] eligible;
  logic             arb_hit;
  logic [2:0]       arb_idx;
  logic [IW-1:0]    sel;
  int               idx;
  logic [133:0]     word, emit_data;
  logic [1:0]       wtype;
  logic             emit, done_set, pkt_inc, err_inc;

  // Pop contract: ov_rd[g] high means the FWFT head of FIFO g is consumed at
  // this clock edge; the source guarantees valid data whenever it is asserted.
  assign eligible    = iv_pkt_valid & iv_src_en;
  assign word        = iv_data[134*int'(grant) +: 134];
  assign wtype       = word[133:132];
  assign o_busy      = (state != S_IDLE);
  assign ov_rd       = (state == S_XFER || state == S_DRAIN) ? (N_SRC'(1) << grant) : '0;
  assign ov_grant_id = grant;

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(rr_ptr) + i) % N_SRC;
      sel = IW'(idx);
      if (!arb_hit && eligible[sel]) begin
        arb_hit = 1'b1;
        arb_idx = 3'(idx);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    emit      = 1'b0;
    emit_data = word;
    done_set  = 1'b0;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;
    case (state)
      S_IDLE: if (arb_hit) state_nx = S_XFER;
      S_XFER: begin
        if (word_cnt == '0 && wtype != T_HEAD) begin
          // Bad head: swallow silently; a lone tail already ends the packet.
          err_inc = 1'b1;
          if (wtype == T_TAIL) begin
            done_set = 1'b1;
            state_nx = S_GAP;
          end else begin
            state_nx = S_DRAIN;
          end
        end else if (wtype == T_TAIL) begin
          emit     = 1'b1;
          done_set = 1'b1;
          pkt_inc  = 1'b1;
          state_nx = S_GAP;
        end else if (word_cnt == WCW'(MAX_WORDS - 1)) begin
          emit      = 1'b1;
          emit_data = {T_TAIL, word[131:0]};
          err_inc   = 1'b1;
          state_nx  = S_DRAIN;
        end else begin
          emit = 1'b1;
        end
      end
      S_DRAIN: if (wtype == T_TAIL) begin
        done_set = 1'b1;
        state_nx = S_GAP;
      end
      S_GAP: if (gap_cnt == 8'(IPG_CYCLES - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= 3'(N_SRC - 1);
      grant       <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      ov_data     <= '0;
      o_data_wr   <= 1'b0;
      ov_pkt_done <= '0;
      ov_pkt_cnt  <= '0;
      ov_err_cnt  <= '0;
    end else begin
      state       <= state_nx;
      o_data_wr   <= emit;
      ov_pkt_done <= done_set ? (N_SRC'(1) << grant) : '0;
      if (emit) ov_data <= emit_data;
      if (state == S_IDLE && arb_hit) begin
        rr_ptr   <= arb_idx;
        grant    <= arb_idx;
        word_cnt <= '0;
      end else if (state == S_XFER) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (state != S_GAP) gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 8'd1;
      if (pkt_inc && ov_pkt_cnt != '1) ov_pkt_cnt <= ov_pkt_cnt + 32'd1;
      if (err_inc && ov_err_cnt != '1) ov_err_cnt <= ov_err_cnt + 16'd1;
    end
  end

endmodule
